// File: rtl/sdhci_rsp_pkg.sv
// Shared definitions for the SD response receive path.
//   rsp_state_e   : receiver FSM states
//   RSP_LEN_*     : frame lengths in bits (R1/R1b/R3/R6/R7 and R2)
//   CRC7_POLY     : x^7 + x^3 + 1 with the x^7 term implied
package sdhci_rsp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    TX_BIT,
    PAYLOAD,
    END_BIT,
    DONE
  } rsp_state_e;

  localparam int         RSP_LEN_SHORT = 48;
  localparam int         RSP_LEN_LONG  = 136;
  localparam logic [6:0] CRC7_POLY     = 7'h09;

endpackage

// File: rtl/crc7_ser_update.sv
// One serial step of the SD CRC7 (x^7 + x^3 + 1), purely combinational.
//   crc_i : CRC register before this bit
//   d_i   : data bit, MSB-first
//   crc_o : CRC register after this bit
module crc7_ser_update
  import sdhci_rsp_pkg::*;
(
  input  logic [6:0] crc_i,
  input  logic       d_i,
  output logic [6:0] crc_o
);

  logic w_fb;

  assign w_fb  = d_i ^ crc_i[6];
  assign crc_o = {crc_i[5:0], 1'b0} ^ (w_fb ? CRC7_POLY : 7'h00);

endmodule

// File: rtl/rsp_receiver.sv
// SD command-response deserialiser.
// Armed by start_listening_i, waits up to TIMEOUT_CYCLES for the start bit,
// shifts in a 48-bit or 136-bit frame, checks CRC7 and framing bits and
// presents the parallel response with a one-cycle rsp_valid_o pulse.
//   sd_clk_i / rst_ni        : clock, asynchronous active-low reset
//   start_listening_i        : arm pulse (ignored outside IDLE)
//   long_rsp_i, check_crc_i  : frame type and CRC-check enable, latched on arm
//   rsp_ser_i                : CMD line
//   receiving_o, rsp_valid_o : busy flag, done pulse
//   index_o, rsp_o           : decoded response (held until the next arm)
//   crc_err_o, end_bit_err_o, timeout_err_o : error status (held likewise)
module rsp_receiver
  import sdhci_rsp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic         sd_clk_i,
  input  logic         rst_ni,
  input  logic         start_listening_i,
  input  logic         long_rsp_i,
  input  logic         check_crc_i,
  input  logic         rsp_ser_i,
  output logic         receiving_o,
  output logic         rsp_valid_o,
  output logic [5:0]   index_o,
  output logic [127:0] rsp_o,
  output logic         crc_err_o,
  output logic         end_bit_err_o,
  output logic         timeout_err_o
);

  localparam int               TO_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
  // The counter holds the frame index of the bit currently on the line.
  localparam logic [CNT_W-1:0] FIRST_SHORT = CNT_W'(RSP_LEN_SHORT - 3);
  localparam logic [CNT_W-1:0] FIRST_LONG  = CNT_W'(RSP_LEN_LONG - 3);
  localparam logic [CNT_W-1:0] CRC_LO      = CNT_W'(8);
  localparam logic [CNT_W-1:0] LONG_CRC_HI = CNT_W'(127);
  localparam logic [CNT_W-1:0] LAST_DATA   = CNT_W'(1);

  rsp_state_e       r_state, w_state_next;
  logic             r_long, r_chk, r_tx_err;
  logic [TO_W-1:0]  r_to_cnt;
  logic [CNT_W-1:0] r_bit_cnt;
  // Holds frame bits 127:1 of an R2 (bit k at [k-1]); a short frame only
  // uses [44:0], the upper bits keep stale data that is never read.
  logic [126:0]     r_shreg;
  logic [6:0]       r_crc;
  logic [5:0]       r_index;
  logic [127:0]     r_rsp;
  logic             r_crc_err, r_eb_err, r_to_err;

  logic [6:0]       w_crc_seed, w_crc_next;
  logic [TO_W-1:0]  w_to_cnt_inc;
  logic             w_timeout, w_covered;

  // The CRC restarts from zero on the start bit; seeding the step with zero
  // there lets a short frame fold the start bit in on the same edge.
  assign w_crc_seed   = (r_state == WAIT_START) ? 7'h00 : r_crc;
  assign w_to_cnt_inc = r_to_cnt + TO_W'(1);
  assign w_timeout    = rsp_ser_i && (w_to_cnt_inc == TO_LAST);
  // R2 leaves its reserved bits 133:128 out of the CRC.
  assign w_covered    = (r_bit_cnt >= CRC_LO) && (!r_long || (r_bit_cnt <= LONG_CRC_HI));

  crc7_ser_update u_crc7 (
    .crc_i (w_crc_seed),
    .d_i   (rsp_ser_i),
    .crc_o (w_crc_next)
  );

  always_ff @(posedge sd_clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:       if (start_listening_i) w_state_next = WAIT_START;
      WAIT_START: begin
        if (!rsp_ser_i)     w_state_next = TX_BIT;
        else if (w_timeout) w_state_next = DONE;
      end
      TX_BIT:     w_state_next = PAYLOAD;
      PAYLOAD:    if (r_bit_cnt == LAST_DATA) w_state_next = END_BIT;
      END_BIT:    w_state_next = DONE;
      DONE:       w_state_next = IDLE;
      default:    w_state_next = IDLE;
    endcase
  end

  always_comb begin
    receiving_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (r_state)
      WAIT_START, TX_BIT, PAYLOAD, END_BIT: receiving_o = 1'b1;
      DONE:                                 rsp_valid_o = 1'b1;
      default:                              ;
    endcase
  end

  always_ff @(posedge sd_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_long    <= 1'b0;
      r_chk     <= 1'b0;
      r_tx_err  <= 1'b0;
      r_to_cnt  <= '0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_crc     <= '0;
      r_index   <= '0;
      r_rsp     <= '0;
      r_crc_err <= 1'b0;
      r_eb_err  <= 1'b0;
      r_to_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_listening_i) begin
            r_long    <= long_rsp_i;
            r_chk     <= check_crc_i;
            r_tx_err  <= 1'b0;
            r_to_cnt  <= '0;
            r_index   <= '0;
            r_rsp     <= '0;
            r_crc_err <= 1'b0;
            r_eb_err  <= 1'b0;
            r_to_err  <= 1'b0;
          end
        end
        WAIT_START: begin
          if (!rsp_ser_i) begin
            r_crc <= r_long ? 7'h00 : w_crc_next;
          end else begin
            r_to_cnt <= w_to_cnt_inc;
            if (w_timeout) r_to_err <= 1'b1;
          end
        end
        TX_BIT: begin
          r_tx_err  <= rsp_ser_i;
          r_bit_cnt <= r_long ? FIRST_LONG : FIRST_SHORT;
          if (!r_long) r_crc <= w_crc_next;
        end
        PAYLOAD: begin
          r_shreg   <= {r_shreg[125:0], rsp_ser_i};
          r_bit_cnt <= r_bit_cnt - CNT_W'(1);
          if (w_covered) r_crc <= w_crc_next;
        end
        END_BIT: begin
          // r_shreg[6:0] now holds the received CRC field (bits 7:1).
          r_eb_err  <= r_tx_err | ~rsp_ser_i;
          r_crc_err <= r_chk & (r_crc != r_shreg[6:0]);
          r_index   <= r_long ? 6'h3F : r_shreg[44:39];
          r_rsp     <= r_long ? {r_shreg[126:0], 1'b0} : {96'b0, r_shreg[38:7]};
        end
        default: ;
      endcase
    end
  end

  assign index_o       = r_index;
  assign rsp_o         = r_rsp;
  assign crc_err_o     = r_crc_err;
  assign end_bit_err_o = r_eb_err;
  assign timeout_err_o = r_to_err;

endmodule

// File: tb/tb_rsp_receiver.sv
module tb_rsp_receiver;

  localparam int TO = 64;

  typedef struct {
    int           at;
    logic [5:0]   idx;
    logic [127:0] rsp;
    logic         ce;
    logic         ee;
    logic         te;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n, start, lng, chk, ser;
  logic         receiving, valid, crc_err, eb_err, to_err;
  logic [5:0]   idx;
  logic [127:0] rsp;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t e_chk;

  rsp_receiver #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .sd_clk_i          (clk),
    .rst_ni            (rst_n),
    .start_listening_i (start),
    .long_rsp_i        (lng),
    .check_crc_i       (chk),
    .rsp_ser_i         (ser),
    .receiving_o       (receiving),
    .rsp_valid_o       (valid),
    .index_o           (idx),
    .rsp_o             (rsp),
    .crc_err_o         (crc_err),
    .end_bit_err_o     (eb_err),
    .timeout_err_o     (to_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // CRC7 as the remainder of msg(x)*x^7 divided by x^7+x^3+1 (long division).
  function automatic logic [6:0] crc7_div(input logic [119:0] msg, input int n);
    logic [126:0] r;
    r = {msg, 7'b0};
    for (int i = n + 6; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  // Expected outputs straight from the frame layout.
  function automatic exp_t model(input logic [135:0] f, input bit long, input bit c);
    exp_t e;
    e.at = 0;
    e.te = 1'b0;
    if (long) begin
      e.idx = 6'h3F;
      e.rsp = {f[127:1], 1'b0};
      e.ce  = c && (crc7_div(f[127:8], 120) != f[7:1]);
      e.ee  = f[134] | ~f[0];
    end else begin
      e.idx = f[45:40];
      e.rsp = {96'b0, f[39:8]};
      e.ce  = c && (crc7_div({80'b0, f[47:8]}, 40) != f[7:1]);
      e.ee  = f[46] | ~f[0];
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Valid is expected in the (len+1)-th cycle counting the start-bit cycle
  // as the first; a timeout exactly TO cycles after the arming cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid: got valid at cycle %0d, required none", cyc);
        end else begin
          e_chk = q.pop_front();
          check("latency",   128'(cyc),       128'(e_chk.at));
          check("index",     128'(idx),       128'(e_chk.idx));
          check("rsp",       rsp,             e_chk.rsp);
          check("crc_err",   128'(crc_err),   128'(e_chk.ce));
          check("end_err",   128'(eb_err),    128'(e_chk.ee));
          check("to_err",    128'(to_err),    128'(e_chk.te));
          check("receiving", 128'(receiving), 128'(0));
        end
      end else if (q.size() != 0 && cyc > q[0].at) begin
        checks++;
        errors++;
        $display("FAIL missing_valid: got none by cycle %0d, required at %0d", cyc, q[0].at);
        void'(q.pop_front());
      end
    end
  end

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 400) begin
      tick();
      k++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d responses outstanding, required 0", q.size());
      q.delete();
      tick();
    end
  endtask

  task automatic send(input logic [135:0] f, input bit long, input bit c, input int gap,
                      input bit mid_arm, input bit use_lit, input exp_t lit);
    int   len;
    exp_t e;
    len   = long ? 136 : 48;
    start = 1'b1;
    lng   = long;
    chk   = c;
    tick();
    start = 1'b0;
    lng   = 1'($urandom);
    chk   = 1'($urandom);
    repeat (gap) tick();
    for (int i = len - 1; i >= 0; i--) begin
      ser = f[i];
      if (i == len - 1) begin
        e    = use_lit ? lit : model(f, long, c);
        e.at = cyc + len;
        q.push_back(e);
      end
      start = mid_arm && (i == len / 2);
      tick();
    end
    start = 1'b0;
    ser   = 1'b1;
    drain();
  endtask

  task automatic arm_timeout();
    exp_t e;
    ser   = 1'b1;
    start = 1'b1;
    lng   = 1'($urandom);
    chk   = 1'($urandom);
    e     = '{at: cyc + TO, idx: 6'h0, rsp: 128'h0, ce: 1'b0, ee: 1'b0, te: 1'b1};
    q.push_back(e);
    tick();
    start = 1'b0;
    drain();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_receiving"}, 128'(receiving), 128'(0));
    check({tag, "_valid"},     128'(valid),     128'(0));
    check({tag, "_index"},     128'(idx),       128'(0));
    check({tag, "_rsp"},       rsp,             128'(0));
    check({tag, "_crc_err"},   128'(crc_err),   128'(0));
    check({tag, "_end_err"},   128'(eb_err),    128'(0));
    check({tag, "_to_err"},    128'(to_err),    128'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish by 5 ms, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [135:0] f;
    logic [127:0] r;
    exp_t         lit;
    bit           long, c;

    rst_n = 1'b0;
    start = 1'b0;
    lng   = 1'b0;
    chk   = 1'b0;
    ser   = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Model pins against well-known SD CRC7 values and the R7 example.
    check("pin_crc_cmd0", 128'(crc7_div({80'b0, 40'h4000000000}, 40)), 128'(7'h4A));
    check("pin_crc_cmd8", 128'(crc7_div({80'b0, 40'h48000001AA}, 40)), 128'(7'h43));
    check("pin_crc_r7",   128'(crc7_div({80'b0, 40'h08000001AA}, 40)), 128'(7'h09));

    // R7, good frame.
    lit = '{at: 0, idx: 6'h08, rsp: 128'h1AA, ce: 1'b0, ee: 1'b0, te: 1'b0};
    send({88'b0, 48'h08_0000_01AA_13}, 1'b0, 1'b1, 3, 1'b0, 1'b1, lit);
    // R7, corrupted CRC field.
    lit = '{at: 0, idx: 6'h08, rsp: 128'h1AA, ce: 1'b1, ee: 1'b0, te: 1'b0};
    send({88'b0, 48'h08_0000_01AA_15}, 1'b0, 1'b1, 0, 1'b0, 1'b1, lit);
    // R7, end bit low.
    lit = '{at: 0, idx: 6'h08, rsp: 128'h1AA, ce: 1'b0, ee: 1'b1, te: 1'b0};
    send({88'b0, 48'h08_0000_01AA_12}, 1'b0, 1'b1, 5, 1'b0, 1'b1, lit);
    // No start bit at all.
    arm_timeout();

    // R2 with random CID and matching CRC.
    r = {$urandom, $urandom, $urandom, $urandom};
    f = '0;
    f[133:128] = 6'h3F;
    f[127:8]   = r[119:0];
    f[7:1]     = crc7_div(f[127:8], 120);
    f[0]       = 1'b1;
    lit = '{at: 0, idx: 6'h3F, rsp: {f[127:1], 1'b0}, ce: 1'b0, ee: 1'b0, te: 1'b0};
    send(f, 1'b1, 1'b1, 2, 1'b0, 1'b1, lit);

    // R3 with all-ones CRC field and CRC checking disabled.
    f = '0;
    f[47:40] = 8'h3F;
    f[39:8]  = 32'hC0FF_8000;
    f[7:0]   = 8'hFF;
    lit = '{at: 0, idx: 6'h3F, rsp: 128'hC0FF_8000, ce: 1'b0, ee: 1'b0, te: 1'b0};
    send(f, 1'b0, 1'b0, 1, 1'b0, 1'b1, lit);

    // Reset in the middle of a payload, then a clean R7.
    f = {88'b0, 48'h08_0000_01AA_13};
    start = 1'b1;
    lng   = 1'b0;
    chk   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 47; i >= 28; i--) begin
      ser = f[i];
      tick();
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    ser = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    lit = '{at: 0, idx: 6'h08, rsp: 128'h1AA, ce: 1'b0, ee: 1'b0, te: 1'b0};
    send(f, 1'b0, 1'b1, 0, 1'b0, 1'b1, lit);

    // Randomised frames, corruptions, stray arm pulses and timeouts.
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 5) == 0) begin
        arm_timeout();
      end else begin
        long = ($urandom_range(0, 2) == 0);
        c    = ($urandom_range(0, 3) != 0);
        f    = '0;
        if (long) begin
          r          = {$urandom, $urandom, $urandom, $urandom};
          f[133:128] = 6'h3F;
          f[127:8]   = r[119:0];
          f[7:1]     = crc7_div(f[127:8], 120);
          f[0]       = 1'b1;
          if ($urandom_range(0, 5) == 0) f[134] = 1'b1;
        end else begin
          f[45:40] = 6'($urandom);
          f[39:8]  = $urandom;
          f[7:1]   = crc7_div({80'b0, f[47:8]}, 40);
          f[0]     = 1'b1;
          if ($urandom_range(0, 5) == 0) f[46] = 1'b1;
        end
        if ($urandom_range(0, 3) == 0) f[$urandom_range(1, 7)] ^= 1'b1;
        if ($urandom_range(0, 5) == 0) f[0] = 1'b0;
        send(f, long, c, $urandom_range(0, 30), ($urandom_range(0, 3) == 0), 1'b0, lit);
      end
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
